// File: rtl/id_ex_pkg.sv
// Shared field widths, control-bundle slice positions and payload layout for the
// ID/EX pipeline register.
package id_ex_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned SHAMT_W = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned CTRL_W  = 8;

  localparam int unsigned WB_MSB  = 7;
  localparam int unsigned WB_LSB  = 6;
  localparam int unsigned MEM_MSB = 5;
  localparam int unsigned MEM_LSB = 4;
  localparam int unsigned EX_MSB  = 3;
  localparam int unsigned EX_LSB  = 0;

  // Fixed-width part of the payload; the DATA_W-wide fields are appended by the top.
  typedef struct packed {
    logic [WB_MSB-WB_LSB:0]   wb;
    logic [MEM_MSB-MEM_LSB:0] mem;
    logic [EX_MSB-EX_LSB:0]   ex;
    logic [REG_W-1:0]         rs;
    logic [REG_W-1:0]         rt;
    logic [REG_W-1:0]         rd;
    logic [SHAMT_W-1:0]       shamt;
    logic [FUNCT_W-1:0]       funct;
  } id_ex_fields_t;

endpackage

// File: rtl/id_ex_pipe_reg.sv
// Generic pipeline register: synchronous active-low clear, then flush, then hold.
module id_ex_pipe_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             hold_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_d, q_q;

  always_comb begin
    q_d = d_i;
    if (flush_i) begin
      q_d = '0;
    end else if (hold_i) begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/id_ex.sv
// ID/EX pipeline register. Define ID_EX_HAZARD_EN to add the Stall_ID/Flush_ID ports;
// without it the register loads on every edge unless in reset.
module id_ex
  import id_ex_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [4:0]         Rs_ID,
  input  logic [4:0]         Rt_ID,
  input  logic [4:0]         Rd_ID,
  input  logic [5:0]         Shamt_ID,
  input  logic [5:0]         Funct_ID,
  input  logic [7:0]         ControlUnitOut_ID,
  input  logic [DATA_W-1:0]  RD1_ID,
  input  logic [DATA_W-1:0]  RD2_ID,
  input  logic [DATA_W-1:0]  Ext_Immed_ID,
`ifdef ID_EX_HAZARD_EN
  input  logic               Stall_ID,
  input  logic               Flush_ID,
`endif
  output logic [1:0]         WB_EX,
  output logic [1:0]         MEM_EX,
  output logic [3:0]         EX_EX,
  output logic [4:0]         Rs_EX,
  output logic [4:0]         Rt_EX,
  output logic [4:0]         Rd_EX,
  output logic [5:0]         Shamt_EX,
  output logic [5:0]         Funct_EX,
  output logic [DATA_W-1:0]  RD1_EX,
  output logic [DATA_W-1:0]  RD2_EX,
  output logic [DATA_W-1:0]  Ext_Immed_EX
);

  localparam int unsigned PayW = $bits(id_ex_fields_t) + 3 * DATA_W;

  id_ex_fields_t     fields_id, fields_ex;
  logic              flush, hold;
  logic [PayW-1:0]   pay_q;

`ifdef ID_EX_HAZARD_EN
  assign flush = Flush_ID;
  assign hold  = Stall_ID;
`else
  assign flush = 1'b0;
  assign hold  = 1'b0;
`endif

  always_comb begin
    fields_id       = '0;
    fields_id.wb    = ControlUnitOut_ID[WB_MSB:WB_LSB];
    fields_id.mem   = ControlUnitOut_ID[MEM_MSB:MEM_LSB];
    fields_id.ex    = ControlUnitOut_ID[EX_MSB:EX_LSB];
    fields_id.rs    = Rs_ID;
    fields_id.rt    = Rt_ID;
    fields_id.rd    = Rd_ID;
    fields_id.shamt = Shamt_ID;
    fields_id.funct = Funct_ID;
  end

  id_ex_pipe_reg #(
    .Width(PayW)
  ) u_pipe_reg (
    .clk_i  (Clk),
    .rst_ni (Rst),
    .flush_i(flush),
    .hold_i (hold),
    .d_i    ({fields_id, RD1_ID, RD2_ID, Ext_Immed_ID}),
    .q_o    (pay_q)
  );

  assign {fields_ex, RD1_EX, RD2_EX, Ext_Immed_EX} = pay_q;

  assign WB_EX    = fields_ex.wb;
  assign MEM_EX   = fields_ex.mem;
  assign EX_EX    = fields_ex.ex;
  assign Rs_EX    = fields_ex.rs;
  assign Rt_EX    = fields_ex.rt;
  assign Rd_EX    = fields_ex.rd;
  assign Shamt_EX = fields_ex.shamt;
  assign Funct_EX = fields_ex.funct;

endmodule

// File: tb/tb_id_ex.sv
// Self-checking bench for id_ex: vector table, latency/hazard sequences, random vs model.
module tb_id_ex;

  localparam int DATA_W = 32;

  typedef struct packed {
    logic [7:0]        ctrl;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [5:0]        shamt;
    logic [5:0]        funct;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
  } pay_t;

  typedef struct {
    string name;
    logic  rst;
    pay_t  in;
    pay_t  exp;
  } vec_t;

  logic              Clk = 1'b0;
  logic              Rst;
  logic [4:0]        Rs_ID, Rt_ID, Rd_ID;
  logic [5:0]        Shamt_ID, Funct_ID;
  logic [7:0]        ControlUnitOut_ID;
  logic [DATA_W-1:0] RD1_ID, RD2_ID, Ext_Immed_ID;
`ifdef ID_EX_HAZARD_EN
  logic              Stall_ID, Flush_ID;
`endif
  logic [1:0]        WB_EX, MEM_EX;
  logic [3:0]        EX_EX;
  logic [4:0]        Rs_EX, Rt_EX, Rd_EX;
  logic [5:0]        Shamt_EX, Funct_EX;
  logic [DATA_W-1:0] RD1_EX, RD2_EX, Ext_Immed_EX;

  int n_checks = 0;
  int n_pass   = 0;

  id_ex #(
    .DATA_W(DATA_W)
  ) dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .Rs_ID            (Rs_ID),
    .Rt_ID            (Rt_ID),
    .Rd_ID            (Rd_ID),
    .Shamt_ID         (Shamt_ID),
    .Funct_ID         (Funct_ID),
    .ControlUnitOut_ID(ControlUnitOut_ID),
    .RD1_ID           (RD1_ID),
    .RD2_ID           (RD2_ID),
    .Ext_Immed_ID     (Ext_Immed_ID),
`ifdef ID_EX_HAZARD_EN
    .Stall_ID         (Stall_ID),
    .Flush_ID         (Flush_ID),
`endif
    .WB_EX            (WB_EX),
    .MEM_EX           (MEM_EX),
    .EX_EX            (EX_EX),
    .Rs_EX            (Rs_EX),
    .Rt_EX            (Rt_EX),
    .Rd_EX            (Rd_EX),
    .Shamt_EX         (Shamt_EX),
    .Funct_EX         (Funct_EX),
    .RD1_EX           (RD1_EX),
    .RD2_EX           (RD2_EX),
    .Ext_Immed_EX     (Ext_Immed_EX)
  );

  always #5 Clk = ~Clk;

  task automatic drive(input pay_t p);
    ControlUnitOut_ID = p.ctrl;
    Rs_ID             = p.rs;
    Rt_ID             = p.rt;
    Rd_ID             = p.rd;
    Shamt_ID          = p.shamt;
    Funct_ID          = p.funct;
    RD1_ID            = p.rd1;
    RD2_ID            = p.rd2;
    Ext_Immed_ID      = p.imm;
  endtask

  function automatic pay_t observed();
    pay_t p;
    p.ctrl  = {WB_EX, MEM_EX, EX_EX};
    p.rs    = Rs_EX;
    p.rt    = Rt_EX;
    p.rd    = Rd_EX;
    p.shamt = Shamt_EX;
    p.funct = Funct_EX;
    p.rd1   = RD1_EX;
    p.rd2   = RD2_EX;
    p.imm   = Ext_Immed_EX;
    return p;
  endfunction

  task automatic check(input string name, input pay_t exp);
    pay_t got;
    got = observed();
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic pay_t rand_pay();
    pay_t p;
    p.ctrl  = 8'($urandom);
    p.rs    = 5'($urandom);
    p.rt    = 5'($urandom);
    p.rd    = 5'($urandom);
    p.shamt = 6'($urandom);
    p.funct = 6'($urandom);
    p.rd1   = $urandom;
    p.rd2   = $urandom;
    p.imm   = $urandom;
    return p;
  endfunction

  pay_t zero, ones, ld, alt, cur;
  vec_t vecs[6];

  initial begin
    pay_t model;
    logic r_rst;
    logic r_stall;
    logic r_flush;

    zero = '0;
    ones = '1;
    ld   = '{ctrl: 8'h3F, rs: 5'd5, rt: 5'd3, rd: 5'd2, shamt: 6'd4, funct: 6'd12,
             rd1: 32'd100, rd2: 32'd200, imm: 32'd150};
    alt  = '{ctrl: 8'hA5, rs: 5'd31, rt: 5'd17, rd: 5'd9, shamt: 6'd63, funct: 6'd33,
             rd1: 32'hDEADBEEF, rd2: 32'h80000000, imm: 32'hFFFFFFFF};

    vecs[0] = '{name: "reset_all_ones", rst: 1'b0, in: ones, exp: zero};
    vecs[1] = '{name: "load_basic",     rst: 1'b1, in: ld,   exp: ld};
    vecs[2] = '{name: "load_alt",       rst: 1'b1, in: alt,  exp: alt};
    vecs[3] = '{name: "reset_loaded",   rst: 1'b0, in: ld,   exp: zero};
    vecs[4] = '{name: "load_zero",      rst: 1'b1, in: zero, exp: zero};
    vecs[5] = '{name: "load_ones",      rst: 1'b1, in: ones, exp: ones};

`ifdef ID_EX_HAZARD_EN
    Stall_ID = 1'b0;
    Flush_ID = 1'b0;
`endif
    Rst = 1'b0;
    drive(ones);
    #2;

    for (int i = 0; i < 6; i++) begin
      Rst = vecs[i].rst;
      drive(vecs[i].in);
      tick();
      check(vecs[i].name, vecs[i].exp);
    end

    // Mid-cycle input change must not reach the outputs before the next edge.
    Rst = 1'b1;
    drive(ld);
    tick();
    check("latency_load", ld);
    cur      = ld;
    cur.ctrl = 8'hC0;
    cur.rd1  = 32'd7;
    #2;
    drive(cur);
    #1;
    check("no_comb_path", ld);
    tick();
    check("latency_update", cur);

`ifdef ID_EX_HAZARD_EN
    drive(ld);
    tick();
    check("stall_preload", ld);
    cur     = ld;
    cur.rd1 = 32'd999;
    drive(cur);
    Stall_ID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_hold", ld);
    end
    Stall_ID = 1'b0;
    tick();
    check("stall_release", cur);

    cur      = ld;
    cur.ctrl = 8'hFF;
    drive(cur);
    Stall_ID = 1'b1;
    Flush_ID = 1'b1;
    tick();
    check("flush_over_stall", zero);
    Stall_ID = 1'b0;
    Flush_ID = 1'b0;
`endif

    drive(alt);
    tick();
    check("rst_prio_preload", alt);
    drive(ld);
    Rst = 1'b0;
`ifdef ID_EX_HAZARD_EN
    Stall_ID = 1'b1;
    Flush_ID = 1'b0;
`endif
    tick();
    check("rst_over_stall", zero);
    Rst = 1'b1;
`ifdef ID_EX_HAZARD_EN
    Stall_ID = 1'b0;
`endif

    // Random phase: model holds what the register should contain after each edge.
    model = zero;
    for (int n = 0; n < 400; n++) begin
      cur     = rand_pay();
      r_rst   = ($urandom_range(0, 15) != 0);
      r_stall = ($urandom_range(0, 3) == 0);
      r_flush = ($urandom_range(0, 7) == 0);
      drive(cur);
      Rst = r_rst;
`ifdef ID_EX_HAZARD_EN
      Stall_ID = r_stall;
      Flush_ID = r_flush;
      if (!r_rst || r_flush) model = zero;
      else if (!r_stall) model = cur;
`else
      if (!r_rst) model = zero;
      else model = cur;
`endif
      tick();
      check("random", model);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex.md
# id_ex

ID/EX pipeline register of the five-stage pipelined MIPS-style processor. It captures decoded instruction fields, register-file read data, the sign-extended immediate and the 8-bit control-unit bundle at the end of the ID stage. It presents them to the EX stage one clock later, with the control bundle split into its WB, MEM and EX groups. Optional hazard support adds stall (hold) and flush (bubble) control.

## Interface
Parameters:
- DATA_W, 32, width of the register-data and immediate paths.

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-low reset; sampled on the rising edge of Clk.
- Rs_ID, Rt_ID, Rd_ID  in  5 each  register specifiers from decode.
- Shamt_ID  in  6  shift amount field.
- Funct_ID  in  6  function field.
- ControlUnitOut_ID  in  8  control bundle: [7:6] WB, [5:4] MEM, [3:0] EX.
- RD1_ID, RD2_ID  in  DATA_W each  register-file read data.
- Ext_Immed_ID  in  DATA_W  sign-extended immediate.
- Stall_ID  in  1  hold the current contents. Present only with ID_EX_HAZARD_EN.
- Flush_ID  in  1  insert a bubble. Present only with ID_EX_HAZARD_EN.
- WB_EX  out  2  registered ControlUnitOut_ID[7:6].
- MEM_EX  out  2  registered ControlUnitOut_ID[5:4].
- EX_EX  out  4  registered ControlUnitOut_ID[3:0].
- Rs_EX, Rt_EX, Rd_EX  out  5 each  registered specifiers.
- Shamt_EX, Funct_EX  out  6 each  registered fields.
- RD1_EX, RD2_EX, Ext_Immed_EX  out  DATA_W each  registered data.

## Operation
- Every output is driven directly by a flip-flop. There is no combinational path from any input to any output.
- On each rising edge of Clk, priority from highest to lowest:
  1. Rst == 0: all outputs become 0.
  2. Flush_ID == 1: all outputs become 0. This bubble is a NOP because all control bits are 0.
  3. Stall_ID == 1: all outputs keep their current values.
  4. Otherwise: each output loads its corresponding _ID input.
- The control bundle is split by fixed bit slices. There is no decoding or modification of any field.
- Widths pass through 1:1. There is no extension or truncation.
- Flush is applied to every field, not only to the control fields, so bubbles are deterministic.

## Timing
- Latency: exactly one cycle. A value presented before edge N appears on the outputs after edge N.
- Reset value of every output is 0.
- Reset is synchronous:
  - Asserting Rst between edges has no effect until the next rising edge.
  - Deasserting Rst lets the first load occur on the next rising edge where Rst is sampled high.
- Rst held low overrides Flush_ID and Stall_ID.
- Flush_ID and Stall_ID both high: flush wins.
- Stall held for K cycles: the outputs are frozen for K edges, then the held inputs load normally.
- Before the first reset the outputs are undefined. The bench must reset before checking.

## Configuration
- ID_EX_HAZARD_EN defined:
  - Stall_ID and Flush_ID ports exist.
  - The priority rules above apply in full.
- ID_EX_HAZARD_EN undefined:
  - Neither port exists.
  - The register loads on every edge unless reset.

## Structure
- Shared package id_ex_pkg holds:
  - Field width constants: REG_W=5, SHAMT_W=6, FUNCT_W=6, CTRL_W=8.
  - Control-bundle slice positions: WB_MSB/LSB=7/6, MEM_MSB/LSB=5/4, EX_MSB/LSB=3/0.
  - A packed struct typedef for the whole ID/EX payload.
- One sub-module is natural: pipe_reg, a generic WIDTH-parameterised register with synchronous active-low clear, flush and hold inputs.
  - Instantiate it once over the packed payload, or once per field.
  - The top level slices its outputs onto the ports.

## Test plan
- Reset: drive all inputs nonzero and Rst=0 for one edge -> every output is 0.
- Load: Rst=1 with Rs=5, Rt=3, Rd=2, Shamt=4, Funct=12, ControlUnitOut=8'h3F, RD1=100, RD2=200, Ext_Immed=150. After one edge the outputs are:
  - WB_EX=00, MEM_EX=11, EX_EX=1111.
  - Rs_EX=5, Rt_EX=3, Rd_EX=2, Shamt_EX=4, Funct_EX=12.
  - RD1_EX=100, RD2_EX=200, Ext_Immed_EX=150.
- Latency and no combinational path: change inputs mid-cycle to ControlUnitOut=8'hC0 and RD1=7 -> outputs unchanged until the next edge, then WB_EX=11, MEM_EX=00, EX_EX=0000, RD1_EX=7.
- Stall (HAZARD_EN): load the values from the Load scenario, then Stall_ID=1 for 3 edges while inputs change to RD1=999 -> RD1_EX stays 100. Release the stall -> RD1_EX=999 after one edge.
- Flush priority (HAZARD_EN): Flush_ID=1 and Stall_ID=1 with ControlUnitOut=8'hFF -> all outputs 0 after the edge.
- Reset priority mid-operation: Rst=0 together with Flush_ID=0, Stall_ID=1 and loaded nonzero state -> all outputs 0 after the edge.
